// File: rtl/carregador_programa.sv
// UART boot loader: receives a word count and big-endian 32-bit words over 8N1 serial,
// writes them to instruction memory and releases the processor reset when done.
module carregador_programa #(
    parameter int unsigned CLKS_POR_BIT = 434,
    parameter int unsigned PALAVRAS     = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    output logic        mem_we,
    output logic [31:0] mem_endereco,
    output logic [31:0] mem_dado,
    output logic        cpu_reset_n,
    output logic        carregado,
    output logic        erro
);
    localparam int unsigned CW = $clog2(CLKS_POR_BIT + 1);
    localparam int unsigned IW = $clog2(PALAVRAS + 1);
    localparam logic [CW-1:0] MEIO    = CW'(CLKS_POR_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_FIM = CW'(CLKS_POR_BIT - 1);

    typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} rx_estado_t;
    typedef enum logic [1:0] {ESPERA_N, RECEBE, CONCLUIDO, ERRO} ld_estado_t;

    logic          rx_meta, rx_sync;
    rx_estado_t    rx_estado;
    logic [CW-1:0] cnt;
    logic [2:0]    n_bit;
    logic [7:0]    deslocador;
    logic          byte_ok, quadro_erro;

    ld_estado_t    estado;
    logic [7:0]    n_palavras;
    logic [1:0]    n_byte;
    logic [23:0]   palavra;
    logic [IW-1:0] indice;
    logic          fim;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_estado   <= OCIOSO;
            cnt         <= '0;
            n_bit       <= '0;
            deslocador  <= '0;
            byte_ok     <= 1'b0;
            quadro_erro <= 1'b0;
        end else begin
            byte_ok     <= 1'b0;
            quadro_erro <= 1'b0;
            case (rx_estado)
                OCIOSO: begin
                    cnt <= '0;
                    if (!rx_sync) rx_estado <= INICIO;
                end
                INICIO: begin
                    if (cnt == MEIO) begin
                        cnt   <= '0;
                        n_bit <= '0;
                        rx_estado <= rx_sync ? OCIOSO : DADOS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DADOS: begin
                    if (cnt == BIT_FIM) begin
                        cnt        <= '0;
                        deslocador <= {rx_sync, deslocador[7:1]};
                        if (n_bit == 3'd7) rx_estado <= PARADA;
                        else               n_bit     <= n_bit + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARADA: begin
                    if (cnt == BIT_FIM) begin
                        cnt         <= '0;
                        byte_ok     <= rx_sync;
                        quadro_erro <= !rx_sync;
                        rx_estado   <= OCIOSO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_estado <= OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado       <= ESPERA_N;
            n_palavras   <= '0;
            n_byte       <= '0;
            palavra      <= '0;
            indice       <= '0;
            fim          <= 1'b0;
            mem_we       <= 1'b0;
            mem_endereco <= '0;
            mem_dado     <= '0;
            cpu_reset_n  <= 1'b0;
            carregado    <= 1'b0;
            erro         <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (estado)
                ESPERA_N: begin
                    if (quadro_erro) begin
                        estado <= ERRO;
                        erro   <= 1'b1;
                    end else if (byte_ok) begin
                        if (byte_ok && (byte_dado_zero() || {24'b0, deslocador} > 32'(PALAVRAS))) begin
                            estado <= ERRO;
                            erro   <= 1'b1;
                        end else begin
                            n_palavras <= deslocador;
                            n_byte     <= '0;
                            estado     <= RECEBE;
                        end
                    end
                end
                RECEBE: begin
                    // fim delays CONCLUIDO by one cycle so the last write strobe precedes it
                    if (fim) begin
                        fim         <= 1'b0;
                        estado      <= CONCLUIDO;
                        carregado   <= 1'b1;
                        cpu_reset_n <= 1'b1;
                    end else if (quadro_erro) begin
                        estado <= ERRO;
                        erro   <= 1'b1;
                    end else if (byte_ok) begin
                        if (n_byte == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_dado     <= {palavra, deslocador};
                            mem_endereco <= 32'({indice, 2'b00});
                            indice       <= indice + 1'b1;
                            fim          <= (32'(indice) + 32'd1 == {24'b0, n_palavras});
                        end else begin
                            palavra <= {palavra[15:0], deslocador};
                        end
                        n_byte <= n_byte + 1'b1;
                    end
                end
                CONCLUIDO: begin
                    carregado   <= 1'b1;
                    cpu_reset_n <= 1'b1;
                end
                ERRO: begin
                    erro        <= 1'b1;
                    carregado   <= 1'b0;
                    cpu_reset_n <= 1'b0;
                end
                default: estado <= ERRO;
            endcase
        end
    end

    function automatic logic byte_dado_zero();
        return deslocador == 8'h00;
    endfunction
endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: serial frames in, memory writes checked
// against a queue of expected (address, data) pairs.
module tb_carregador_programa;
    localparam int unsigned CLKS = 16;
    localparam int unsigned PAL  = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        mem_we;
    logic [31:0] mem_endereco, mem_dado;
    logic        cpu_reset_n, carregado, erro;

    typedef struct {
        logic [31:0] endereco;
        logic [31:0] dado;
        logic        ultima;
    } escrita_t;

    escrita_t sb[$];
    int checks = 0;
    int passed = 0;
    logic chk_fim = 1'b0;

    carregador_programa #(.CLKS_POR_BIT(CLKS), .PALAVRAS(PAL)) dut (
        .clock(clock), .reset_n(reset_n), .rx(rx),
        .mem_we(mem_we), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
        .cpu_reset_n(cpu_reset_n), .carregado(carregado), .erro(erro)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic envia_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        rx = 1'b0;
        repeat (CLKS) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clock);
        end
        rx = stop;
        repeat (CLKS) @(negedge clock);
        rx = 1'b1;
        repeat (2 * CLKS) @(negedge clock);
    endtask

    task automatic espera_escrita(input logic [31:0] end_e, input logic [31:0] dado_e, input logic ult);
        escrita_t e;
        e.endereco = end_e;
        e.dado     = dado_e;
        e.ultima   = ult;
        sb.push_back(e);
    endtask

    task automatic pulso_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        verifica("rst_mem_we", 32'(mem_we), 32'd0);
        verifica("rst_endereco", mem_endereco, 32'd0);
        verifica("rst_dado", mem_dado, 32'd0);
        verifica("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        verifica("rst_carregado", 32'(carregado), 32'd0);
        verifica("rst_erro", 32'(erro), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic estado_final(input string tag, input logic c, input logic e);
        verifica({tag, "_carregado"}, 32'(carregado), 32'(c));
        verifica({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(c));
        verifica({tag, "_erro"}, 32'(erro), 32'(e));
        verifica({tag, "_fila_vazia"}, 32'(sb.size()), 32'd0);
    endtask

    // Write monitor: every strobe must match the head of the queue
    initial begin
        escrita_t e;
        forever begin
            @(negedge clock);
            if (chk_fim) begin
                chk_fim = 1'b0;
                verifica("carregado_apos_ultima", 32'(carregado), 32'd1);
                verifica("cpu_liberada_apos_ultima", 32'(cpu_reset_n), 32'd1);
            end
            if (mem_we === 1'b1) begin
                if (sb.size() == 0) begin
                    verifica("escrita_inesperada", 32'(mem_we), 32'd0);
                end else begin
                    e = sb.pop_front();
                    verifica("endereco", mem_endereco, e.endereco);
                    verifica("dado", mem_dado, e.dado);
                    verifica("carregado_na_escrita", 32'(carregado), 32'd0);
                    if (e.ultima) chk_fim = 1'b1;
                end
            end
        end
    end

    initial begin
        #(200000 * 10);
        $error("FAIL watchdog: simulation time limit expired");
        $fatal(1, "FAIL watchdog");
    end

    initial begin
        pulso_reset();

        // Two-word program
        espera_escrita(32'h0000_0000, 32'h2008_0005, 1'b0);
        espera_escrita(32'h0000_0004, 32'h0109_5020, 1'b1);
        envia_byte(8'h02, 1'b1);
        envia_byte(8'h20, 1'b1); envia_byte(8'h08, 1'b1);
        envia_byte(8'h00, 1'b1); envia_byte(8'h05, 1'b1);
        envia_byte(8'h01, 1'b1); envia_byte(8'h09, 1'b1);
        envia_byte(8'h50, 1'b1); envia_byte(8'h20, 1'b1);
        estado_final("n2", 1'b1, 1'b0);

        // Traffic after completion is ignored
        for (int i = 0; i < 8; i++) envia_byte(8'(8'h11 * i + 1), 1'b1);
        estado_final("pos_concluido", 1'b1, 1'b0);

        // Bad headers
        pulso_reset();
        envia_byte(8'h00, 1'b1);
        envia_byte(8'hAA, 1'b1);
        estado_final("hdr_zero", 1'b0, 1'b1);

        pulso_reset();
        envia_byte(8'(PAL + 1), 1'b1);
        for (int i = 0; i < 4; i++) envia_byte(8'h33, 1'b1);
        estado_final("hdr_grande", 1'b0, 1'b1);

        // Framing error on the third data byte; the trailing byte must not complete a word
        pulso_reset();
        envia_byte(8'h01, 1'b1);
        envia_byte(8'hAA, 1'b1);
        envia_byte(8'hBB, 1'b1);
        envia_byte(8'hCC, 1'b0);
        envia_byte(8'hDD, 1'b1);
        estado_final("quadro", 1'b0, 1'b1);

        // Start-bit glitch rejected, then a valid single-word load
        pulso_reset();
        @(negedge clock);
        rx = 1'b0;
        repeat (CLKS / 4) @(negedge clock);
        rx = 1'b1;
        repeat (2 * CLKS) @(negedge clock);
        verifica("glitch_sem_erro", 32'(erro), 32'd0);
        espera_escrita(32'h0000_0000, 32'hDEAD_BEEF, 1'b1);
        envia_byte(8'h01, 1'b1);
        envia_byte(8'hDE, 1'b1); envia_byte(8'hAD, 1'b1);
        envia_byte(8'hBE, 1'b1); envia_byte(8'hEF, 1'b1);
        estado_final("glitch", 1'b1, 1'b0);

        // Reset in the middle of a word abandons it; the reload starts from a new header
        pulso_reset();
        envia_byte(8'h01, 1'b1);
        envia_byte(8'h12, 1'b1); envia_byte(8'h34, 1'b1);
        pulso_reset();
        espera_escrita(32'h0000_0000, 32'h1234_5678, 1'b1);
        envia_byte(8'h01, 1'b1);
        envia_byte(8'h12, 1'b1); envia_byte(8'h34, 1'b1);
        envia_byte(8'h56, 1'b1); envia_byte(8'h78, 1'b1);
        estado_final("reset_meio", 1'b1, 1'b0);

        repeat (4) @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
